// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector load gather engine.
package vec_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} vec_load_state_t;

  // Lane index width; a single-lane vector still needs a 1-bit counter.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_load_gather.sv
// Vector load engine: fetches vectorSize consecutive lanes one request at a time and
// commits them to the vector register file. Optional strided addressing: VEC_LOAD_STRIDE_EN.
module vec_load_gather
  import vec_pkg::*;
#(
  parameter int registerSize  = 16,
  parameter int selectionBits = 2,
  parameter int vectorSize    = 4,
  parameter int addrWidth     = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [addrWidth-1:0]                baseAddr,
  input  logic [selectionBits-1:0]            destReg,
`ifdef VEC_LOAD_STRIDE_EN
  input  logic [addrWidth-1:0]                stride,
`endif
  output logic                                memRdEn,
  output logic [addrWidth-1:0]                memAddr,
  input  logic                                memRdValid,
  input  logic [registerSize-1:0]             memRdData,
  output logic                                busy,
  output logic                                done,
  output logic                                regWrEn,
  output logic [selectionBits-1:0]            regToWrite,
  output logic [vectorSize*registerSize-1:0]  regWriteData
);

  localparam int LW = lane_bits(vectorSize);

  vec_load_state_t state_q, state_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic [addrWidth-1:0]     base_q, base_d;
  logic [selectionBits-1:0] dest_q;
  logic                     capture;
  logic [addrWidth-1:0]     addr_next;
  logic [vectorSize-1:0]    lane_we;
  logic [vectorSize-1:0][registerSize-1:0] buf_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          lane_d  = '0;
          capture = 1'b1;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (memRdValid) begin
          if (lane_q == LW'(vectorSize - 1)) begin
            state_d = COMMIT;
          end else begin
            lane_d  = lane_q + LW'(1);
            state_d = REQ;
          end
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address is computed for the state being entered so memAddr can be a flop.
  assign base_d = capture ? baseAddr : base_q;

`ifdef VEC_LOAD_STRIDE_EN
  logic [addrWidth-1:0] stride_q, stride_d;
  assign stride_d  = capture ? stride : stride_q;
  assign addr_next = base_d + addrWidth'(lane_d) * stride_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stride_q <= '0;
    end else if (capture) begin
      stride_q <= stride;
    end
  end
`else
  assign addr_next = base_d + addrWidth'(lane_d);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      base_q     <= '0;
      dest_q     <= '0;
      memRdEn    <= 1'b0;
      memAddr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      regWrEn    <= 1'b0;
      regToWrite <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (capture) begin
        base_q <= baseAddr;
        dest_q <= destReg;
      end
      memRdEn    <= (state_d == REQ);
      memAddr    <= (state_d == REQ) ? addr_next : '0;
      busy       <= (state_d != IDLE);
      done       <= (state_d == COMMIT);
      regWrEn    <= (state_d == COMMIT);
      regToWrite <= (state_d == COMMIT) ? dest_q : '0;
    end
  end

  // Lane buffer: one enable-gated register per lane, selected by the lane counter.
  always_comb begin
    lane_we = '0;
    for (int j = 0; j < vectorSize; j++) begin
      lane_we[j] = (state_q == WAIT) && memRdValid && (lane_q == LW'(j));
    end
  end

  for (genvar g = 0; g < vectorSize; g++) begin : g_lane
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        buf_q[g] <= '0;
      end else if (lane_we[g]) begin
        buf_q[g] <= memRdData;
      end
    end
  end

  assign regWriteData = buf_q;

endmodule

// File: tb/tb_vec_load_gather.sv
// Directed, table-driven bench for vec_load_gather with a latency-programmable memory model.
module tb_vec_load_gather;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] baseAddr;
  logic [1:0]  destReg;
  logic        memRdEn;
  logic [15:0] memAddr;
  logic        memRdValid;
  logic [15:0] memRdData;
  logic        busy;
  logic        done;
  logic        regWrEn;
  logic [1:0]  regToWrite;
  logic [63:0] regWriteData;
`ifdef VEC_LOAD_STRIDE_EN
  logic [15:0] stride;
`endif

  int errors = 0;
  int checks = 0;

  // Memory model state
  int          resp_delay = 1;
  int          cnt = 0;
  bit          pend = 1'b0;
  logic [15:0] pend_addr = '0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        spur_valid = 1'b0;
  logic [15:0] spur_data = '0;
  logic [15:0] addr_q[$];
  int          wr_cnt = 0;

  assign memRdValid = mem_valid | spur_valid;
  assign memRdData  = spur_valid ? spur_data : mem_data;

  vec_load_gather dut (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .destReg(destReg),
`ifdef VEC_LOAD_STRIDE_EN
    .stride(stride),
`endif
    .memRdEn(memRdEn), .memAddr(memAddr), .memRdValid(memRdValid), .memRdData(memRdData),
    .busy(busy), .done(done), .regWrEn(regWrEn), .regToWrite(regToWrite),
    .regWriteData(regWriteData)
  );

  always #5 clk = ~clk;

  // Memory: answers each request resp_delay cycles later with 0xA000 + address.
  always @(negedge clk) begin
    if (reset) begin
      pend      = 1'b0;
      mem_valid = 1'b0;
    end else begin
      mem_valid = 1'b0;
      if (memRdEn) begin
        addr_q.push_back(memAddr);
        pend      = 1'b1;
        cnt       = resp_delay;
        pend_addr = memAddr;
      end else if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = 16'hA000 + pend_addr;
          pend      = 1'b0;
        end
      end
      if (regWrEn) wr_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] base, input logic [1:0] dst, output int n);
    @(negedge clk);
    addr_q.delete();
    baseAddr = base;
    destReg  = dst;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
  endtask

  task automatic wait_commit(input int n0, output int n);
    n = n0;
    while (regWrEn !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (regWrEn !== 1'b1) chk("commit_timeout", 64'(n), 64'd0);
  endtask

  task automatic do_load(input string tag, input logic [15:0] base, input logic [1:0] dst,
                         input int dly, input int lat, input logic [63:0] ea,
                         input logic [63:0] ed);
    int n;
    int w0;
    resp_delay = dly;
    w0 = wr_cnt;
    launch(base, dst, n);
    wait_commit(n, n);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_data"}, regWriteData, ed);
    chk({tag, "_dest"}, 64'(regToWrite), 64'(dst));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_nreq"}, 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_q.size()) chk({tag, "_addr"}, 64'(addr_q[i]), 64'(ea[16*i +: 16]));
    end
    @(posedge clk);
    #1;
    chk({tag, "_wr_pulse"}, {62'd0, regWrEn, done}, 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_wr_count"}, 64'(wr_cnt - w0), 64'd1);
  endtask

  typedef struct {
    string       tag;
    logic [15:0] base;
    logic [1:0]  dest;
    int          dly;
    int          lat;
    logic [63:0] addrs;
    logic [63:0] data;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int n;
    int w0;
    logic [63:0] snap;

    tbl[0] = '{"unit", 16'h0010, 2'd2, 1, 9,
               {16'h0013, 16'h0012, 16'h0011, 16'h0010}, 64'hA013_A012_A011_A010};
    tbl[1] = '{"slow", 16'h0100, 2'd0, 3, 17,
               {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 64'hA103_A102_A101_A100};
    tbl[2] = '{"wrap", 16'hFFFE, 2'd3, 1, 9,
               {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, 64'hA001_A000_9FFF_9FFE};
    tbl[3] = '{"mid", 16'h1234, 2'd1, 2, 13,
               {16'h1237, 16'h1236, 16'h1235, 16'h1234}, 64'hB237_B236_B235_B234};

    reset    = 1'b1;
    start    = 1'b0;
    baseAddr = '0;
    destReg  = '0;
`ifdef VEC_LOAD_STRIDE_EN
    stride   = 16'd1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_memRdEn", 64'(memRdEn), 64'd0);
    chk("rst_memAddr", 64'(memAddr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_wr", {62'd0, done, regWrEn}, 64'd0);
    chk("rst_regToWrite", 64'(regToWrite), 64'd0);
    chk("rst_data", regWriteData, 64'd0);

    for (int i = 0; i < 4; i++) begin
      do_load(tbl[i].tag, tbl[i].base, tbl[i].dest, tbl[i].dly, tbl[i].lat,
              tbl[i].addrs, tbl[i].data);
    end

    // Start re-pulsed during WAIT of lane 1, then a stray response while idle.
    resp_delay = 1;
    w0 = wr_cnt;
    launch(16'h0030, 2'd2, n);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    chk("restart_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_commit(n + 4, n);
    chk("restart_latency", 64'(n), 64'd9);
    chk("restart_data", regWriteData, 64'hA033_A032_A031_A030);
    @(posedge clk);
    #1;
    chk("restart_not_queued", 64'(busy), 64'd0);
    snap = regWriteData;
    @(negedge clk);
    spur_data  = 16'hDEAD;
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("spurious_buf", regWriteData, snap);
    chk("spurious_busy", 64'(busy), 64'd0);
    chk("restart_wr_count", 64'(wr_cnt - w0), 64'd1);

    // Reset in WAIT of lane 2 discards the partial vector.
    resp_delay = 1;
    w0 = wr_cnt;
    launch(16'h0200, 2'd1, n);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {59'd0, memRdEn, busy, done, regWrEn, |regToWrite}, 64'd0);
    chk("mid_rst_addr", 64'(memAddr), 64'd0);
    chk("mid_rst_data", regWriteData, 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_wr", 64'(wr_cnt - w0), 64'd0);
    chk("mid_rst_idle", 64'(busy), 64'd0);
    do_load("after_rst", 16'h0040, 2'd3, 1, 9,
            {16'h0043, 16'h0042, 16'h0041, 16'h0040}, 64'hA043_A042_A041_A040);

`ifdef VEC_LOAD_STRIDE_EN
    stride = 16'd4;
    do_load("stride4", 16'h0020, 2'd1, 1, 9,
            {16'h002C, 16'h0028, 16'h0024, 16'h0020}, 64'hA02C_A028_A024_A020);
    stride = 16'd0;
    do_load("bcast", 16'h0020, 2'd2, 1, 9,
            {16'h0020, 16'h0020, 16'h0020, 16'h0020}, 64'hA020_A020_A020_A020);
    stride = 16'd1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

endmodule
